lsu_stbuf_queue: RTL and testbench
==================================

// Module: lsu_stbuf_queue
// PURPOSE
//  Store buffer between LSU commit (dc4) and the DCCM/PIC write port.
//  - Queues committed stores as aligned dwords.
//  - Drains the oldest entry to the DCCM/PIC control stage via a request/commit handshake.
//  - Returns byte-granular forwarding data for in-flight loads in dc3 (lo and hi dword).
// PARAMETERS
//  DEPTH      4   entries; power of 2, >=2
//  ADDR_BITS  16  DCCM/PIC byte-address width (RV_DCCM_BITS)
//  DATA_W     64  entry data width; byte enables = DATA_W/8
// PORTS
//  clk                     in   1          core clock
//  rst                     in   1          reset
//  st_valid_dc4            in   1          committed store this cycle
//  st_addr_dc4             in   ADDR_BITS  store byte address; [2:0] ignored
//  st_data_dc4             in   DATA_W     store data, dword-aligned lanes
//  st_byteen_dc4           in   8          bytes written by the store
//  st_in_pic_dc4           in   1          store targets PIC
//  stbuf_full              out  1          count==DEPTH; upstream stalls
//  stbuf_empty             out  1          count==0
//  stbuf_reqvld_any        out  1          head entry valid, requesting port
//  stbuf_addr_any          out  ADDR_BITS  head address, [2:0]=0
//  stbuf_data_any          out  DATA_W     head data
//  stbuf_byteen_any        out  8          head byte enables
//  stbuf_addr_in_pic_any   out  1          head targets PIC
//  lsu_stbuf_commit_any    in   1          port granted; head retires this cycle
//  ld_valid_dc2            in   1          load in dc2
//  ld_addr_lo_dc2          in   ADDR_BITS  load start address
//  ld_addr_hi_dc2          in   ADDR_BITS  load end address
//  stbuf_fwddata_lo_dc3    out  DATA_W     forwarded data for the lo dword
//  stbuf_fwdbyteen_lo_dc3  out  8          valid forwarded bytes for the lo dword
//  stbuf_fwddata_hi_dc3    out  DATA_W     forwarded data for the hi dword
//  stbuf_fwdbyteen_hi_dc3  out  8          valid forwarded bytes for the hi dword
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is asynchronous and active-high.
//  - Reset state: all entries invalid, rd_ptr=wr_ptr=0, count=0.
//    Every output is 0, except stbuf_empty=1.
//  - Storage: circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits) and count (log2 DEPTH+1 bits).
//    Pointers wrap from DEPTH-1 to 0.
//  - Allocate: st_valid_dc4 & ~stbuf_full writes entry[wr_ptr] as follows, then wr_ptr++.
//      addr   = {st_addr_dc4[ADDR_BITS-1:3], 3'b0}
//      data   = st_data_dc4
//      byteen = st_byteen_dc4
//      pic    = st_in_pic_dc4
//  - st_valid_dc4 while stbuf_full is a protocol error: the store is dropped and an assertion fires.
//    Full is evaluated before same-cycle retirement, so no allocation happens on a full cycle.
//  - Drain: stbuf_reqvld_any = ~stbuf_empty. Head fields are driven combinationally from entry[rd_ptr].
//    On lsu_stbuf_commit_any & reqvld: entry invalidated, rd_ptr++.
//    lsu_stbuf_commit_any without reqvld is ignored.
//  - Latency: a store allocated into an empty buffer requests in the next cycle.
//    The head holds stable until commit.
//  - Simultaneous allocate and retire: count unchanged; both pointers advance.
//  - Forwarding, dc2 compare: each valid entry and the same-cycle dc4 store are compared on
//    addr[ADDR_BITS-1:3] against lo and hi separately.
//    The dc4 store is the youngest; priority runs youngest to oldest, per byte.
//    A byte is forwarded only where the matching entry's byteen bit is set.
//    An entry retiring in the same cycle still forwards.
//    PIC entries forward only to loads whose address matches, with no special casing.
//  - Forwarding, dc3 output: results are registered into the dc3 outputs at 1-cycle latency.
//    ld_valid_dc2=0 registers zeros.
//  - lo==hi dword: hi outputs equal lo outputs.
// CONFIGURATION
//  LSU_STBUF_COALESCE_EN defined:
//  - A dc4 store whose dword address and pic flag match the youngest valid entry merges into it,
//    with no allocation.
//      data bytes replaced where st_byteen_dc4=1
//      byteen |= st_byteen_dc4
//  - Coalescing is blocked when the youngest entry is the head and is committing this cycle.
//    In that case a normal allocation occurs.
//  - Merge is permitted even when stbuf_full=1 (full stalls only non-merging stores upstream).
//  LSU_STBUF_COALESCE_EN undefined:
//  - Every store allocates a new entry; no merge logic is present.
// TESTING
//  1. Reset mid-drain:
//     Fill 3 entries, assert rst for 1 cycle -> stbuf_empty=1, reqvld=0, fwd outputs=0 immediately.
//  2. Fill and wrap:
//     Allocate DEPTH stores to addresses 0x100, 0x108, 0x110, 0x118 -> stbuf_full=1.
//     Commit 1 and allocate 0x120 in the next cycle -> entry lands at index 0.
//     The head then drains in order 0x108, 0x110, 0x118, 0x120.
//  3. Overlap on empty:
//     On an empty buffer, allocate and hold commit=1 -> reqvld rises one cycle later.
//     Entry retires the cycle after; count returns to 0.
//  4. Forwarding priority:
//     Entries 0x200 {byteen=0x0F, data=0x..11111111} then 0x200 {byteen=0x03, data=0x..2222}, coalescing off.
//     Load lo=0x200 -> dc3 fwdbyteen_lo=0x0F, bytes[1:0]=0x22, bytes[3:2]=0x11.
//  5. Unaligned load hi path:
//     Entry 0x308 byteen=0xFF; load lo=0x306, hi=0x30D -> fwdbyteen_hi=0xFF, fwdbyteen_lo=0x00.
//  6. Coalescing (LSU_STBUF_COALESCE_EN):
//     Two stores to 0x400 with byteen 0x01 then 0x80 -> count=1, head byteen=0x81.
//     Without the macro -> count=2.

Source files
------------

// File: rtl/lsu_stbuf_queue.sv
// Store buffer between LSU commit (dc4) and the DCCM/PIC write port, with dc3 load forwarding.
// Optional store merging into the youngest entry is enabled by defining LSU_STBUF_COALESCE_EN.
module lsu_stbuf_queue #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 16,
  parameter int DATA_W    = 64,
  localparam int NB       = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid_dc4,
  input  logic [ADDR_BITS-1:0] st_addr_dc4,
  input  logic [DATA_W-1:0]    st_data_dc4,
  input  logic [NB-1:0]        st_byteen_dc4,
  input  logic                 st_in_pic_dc4,
  output logic                 stbuf_full,
  output logic                 stbuf_empty,
  output logic                 stbuf_reqvld_any,
  output logic [ADDR_BITS-1:0] stbuf_addr_any,
  output logic [DATA_W-1:0]    stbuf_data_any,
  output logic [NB-1:0]        stbuf_byteen_any,
  output logic                 stbuf_addr_in_pic_any,
  input  logic                 lsu_stbuf_commit_any,
  input  logic                 ld_valid_dc2,
  input  logic [ADDR_BITS-1:0] ld_addr_lo_dc2,
  input  logic [ADDR_BITS-1:0] ld_addr_hi_dc2,
  output logic [DATA_W-1:0]    stbuf_fwddata_lo_dc3,
  output logic [NB-1:0]        stbuf_fwdbyteen_lo_dc3,
  output logic [DATA_W-1:0]    stbuf_fwddata_hi_dc3,
  output logic [NB-1:0]        stbuf_fwdbyteen_hi_dc3
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AH = ADDR_BITS - 1;

  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0]     data_q, data_d;
  logic [DEPTH-1:0][NB-1:0]         be_q, be_d;
  logic [DEPTH-1:0]                 pic_q, pic_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, yng, idx;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             retire, alloc, st_drop;
  logic [DATA_W-1:0]                fd_lo, fd_hi, fd_lo_q, fd_hi_q;
  logic [NB-1:0]                    fb_lo, fb_hi, fb_lo_q, fb_hi_q;

  assign stbuf_full  = (cnt_q == CW'(DEPTH));
  assign stbuf_empty = (cnt_q == '0);
  assign retire      = lsu_stbuf_commit_any & ~stbuf_empty;
  assign yng         = wr_ptr_q - 1'b1;

`ifdef LSU_STBUF_COALESCE_EN
  logic merge;
  // Merging into a head that leaves this cycle would lose the new bytes, so allocate instead.
  assign merge   = st_valid_dc4 & ~stbuf_empty & vld_q[yng] & (pic_q[yng] == st_in_pic_dc4) &
                   (addr_q[yng][AH:3] == st_addr_dc4[AH:3]) & ~(retire & (yng == rd_ptr_q));
  assign alloc   = st_valid_dc4 & ~stbuf_full & ~merge;
  assign st_drop = st_valid_dc4 & stbuf_full & ~merge;
`else
  assign alloc   = st_valid_dc4 & ~stbuf_full;
  assign st_drop = st_valid_dc4 & stbuf_full;
`endif

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    pic_d  = pic_q;
    if (retire) vld_d[rd_ptr_q] = 1'b0;
    if (alloc) begin
      vld_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q] = {st_addr_dc4[AH:3], 3'b000};
      data_d[wr_ptr_q] = st_data_dc4;
      be_d[wr_ptr_q]   = st_byteen_dc4;
      pic_d[wr_ptr_q]  = st_in_pic_dc4;
    end
`ifdef LSU_STBUF_COALESCE_EN
    if (merge) begin
      for (int b = 0; b < NB; b++)
        if (st_byteen_dc4[b]) data_d[yng][b*8 +: 8] = st_data_dc4[b*8 +: 8];
      be_d[yng] = be_q[yng] | st_byteen_dc4;
    end
`endif
    rd_ptr_d = rd_ptr_q + PW'(retire);
    wr_ptr_d = wr_ptr_q + PW'(alloc);
    cnt_d    = cnt_q + CW'(alloc) - CW'(retire);
  end

  // Walk entries oldest to youngest, then the dc4 store, so younger bytes overwrite older ones.
  always_comb begin
    fd_lo = '0; fb_lo = '0; fd_hi = '0; fb_hi = '0; idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      for (int b = 0; b < NB; b++) begin
        if (vld_q[idx] && be_q[idx][b] && addr_q[idx][AH:3] == ld_addr_lo_dc2[AH:3]) begin
          fd_lo[b*8 +: 8] = data_q[idx][b*8 +: 8]; fb_lo[b] = 1'b1;
        end
        if (vld_q[idx] && be_q[idx][b] && addr_q[idx][AH:3] == ld_addr_hi_dc2[AH:3]) begin
          fd_hi[b*8 +: 8] = data_q[idx][b*8 +: 8]; fb_hi[b] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (st_valid_dc4 && st_byteen_dc4[b] && st_addr_dc4[AH:3] == ld_addr_lo_dc2[AH:3]) begin
        fd_lo[b*8 +: 8] = st_data_dc4[b*8 +: 8]; fb_lo[b] = 1'b1;
      end
      if (st_valid_dc4 && st_byteen_dc4[b] && st_addr_dc4[AH:3] == ld_addr_hi_dc2[AH:3]) begin
        fd_hi[b*8 +: 8] = st_data_dc4[b*8 +: 8]; fb_hi[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0; addr_q <= '0; data_q <= '0; be_q <= '0; pic_q <= '0;
      rd_ptr_q <= '0; wr_ptr_q <= '0; cnt_q <= '0;
      fd_lo_q <= '0; fb_lo_q <= '0; fd_hi_q <= '0; fb_hi_q <= '0;
    end else begin
      vld_q <= vld_d; addr_q <= addr_d; data_q <= data_d; be_q <= be_d; pic_q <= pic_d;
      rd_ptr_q <= rd_ptr_d; wr_ptr_q <= wr_ptr_d; cnt_q <= cnt_d;
      fd_lo_q <= ld_valid_dc2 ? fd_lo : '0;
      fb_lo_q <= ld_valid_dc2 ? fb_lo : '0;
      fd_hi_q <= ld_valid_dc2 ? fd_hi : '0;
      fb_hi_q <= ld_valid_dc2 ? fb_hi : '0;
    end
  end

  assign stbuf_reqvld_any       = ~stbuf_empty;
  assign stbuf_addr_any         = stbuf_reqvld_any ? addr_q[rd_ptr_q] : '0;
  assign stbuf_data_any         = stbuf_reqvld_any ? data_q[rd_ptr_q] : '0;
  assign stbuf_byteen_any       = stbuf_reqvld_any ? be_q[rd_ptr_q]   : '0;
  assign stbuf_addr_in_pic_any  = stbuf_reqvld_any & pic_q[rd_ptr_q];
  assign stbuf_fwddata_lo_dc3   = fd_lo_q;
  assign stbuf_fwdbyteen_lo_dc3 = fb_lo_q;
  assign stbuf_fwddata_hi_dc3   = fd_hi_q;
  assign stbuf_fwdbyteen_hi_dc3 = fb_hi_q;

  // Upstream must stall non-merging stores while full.
  a_no_drop: assert property (@(posedge clk) disable iff (rst) !st_drop);

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Directed table-driven bench for lsu_stbuf_queue (expectations follow LSU_STBUF_COALESCE_EN).
module tb_lsu_stbuf_queue;
`ifdef LSU_STBUF_COALESCE_EN
  localparam bit C = 1'b1;
`else
  localparam bit C = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        st_valid, st_pic, commit, ld_valid;
  logic [15:0] st_addr, ld_lo, ld_hi;
  logic [63:0] st_data;
  logic [7:0]  st_be;
  logic        full, empty, reqvld, hpic;
  logic [15:0] haddr;
  logic [63:0] hdata, flo, fhi;
  logic [7:0]  hbe, flo_be, fhi_be;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_stbuf_queue dut (
    .clk(clk), .rst(rst),
    .st_valid_dc4(st_valid), .st_addr_dc4(st_addr), .st_data_dc4(st_data),
    .st_byteen_dc4(st_be), .st_in_pic_dc4(st_pic),
    .stbuf_full(full), .stbuf_empty(empty), .stbuf_reqvld_any(reqvld),
    .stbuf_addr_any(haddr), .stbuf_data_any(hdata), .stbuf_byteen_any(hbe),
    .stbuf_addr_in_pic_any(hpic), .lsu_stbuf_commit_any(commit),
    .ld_valid_dc2(ld_valid), .ld_addr_lo_dc2(ld_lo), .ld_addr_hi_dc2(ld_hi),
    .stbuf_fwddata_lo_dc3(flo), .stbuf_fwdbyteen_lo_dc3(flo_be),
    .stbuf_fwddata_hi_dc3(fhi), .stbuf_fwdbyteen_hi_dc3(fhi_be)
  );

  typedef struct {
    logic        sv; logic [15:0] a; logic [63:0] d; logic [7:0] be; logic pic; logic cm;
    logic        lv; logic [15:0] llo, lhi;
    logic        efull, eempty; logic [15:0] ha; logic [63:0] hd; logic [7:0] hbe; logic hp;
    logic [7:0]  flb; logic [63:0] fl; logic [7:0] fhb; logic [63:0] fh;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic sv, logic [15:0] a, logic [63:0] d, logic [7:0] be,
                             logic pic, logic cm, logic lv, logic [15:0] llo, logic [15:0] lhi,
                             logic efull, logic eempty, logic [15:0] ha, logic [63:0] hd,
                             logic [7:0] hbe, logic hp, logic [7:0] flb, logic [63:0] fl,
                             logic [7:0] fhb, logic [63:0] fh);
    vec_t r;
    r.sv = sv; r.a = a; r.d = d; r.be = be; r.pic = pic; r.cm = cm;
    r.lv = lv; r.llo = llo; r.lhi = lhi;
    r.efull = efull; r.eempty = eempty; r.ha = ha; r.hd = hd; r.hbe = hbe; r.hp = hp;
    r.flb = flb; r.fl = fl; r.fhb = fhb; r.fh = fh;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic sv, input logic [15:0] a, input logic [63:0] d,
                     input logic [7:0] be, input logic pic, input logic cm,
                     input logic lv, input logic [15:0] llo, input logic [15:0] lhi);
    st_valid = sv; st_addr = a; st_data = d; st_be = be; st_pic = pic;
    commit = cm; ld_valid = lv; ld_lo = llo; ld_hi = lhi;
  endtask

  initial begin
    // fill and wrap
    tv.push_back(v(1,'h103,1,'hFF,0,0, 0,0,0, 0,0,'h100,1,'hFF,0, 0,0,0,0));
    tv.push_back(v(1,'h108,2,'hFF,0,0, 0,0,0, 0,0,'h100,1,'hFF,0, 0,0,0,0));
    tv.push_back(v(1,'h110,3,'hFF,0,0, 0,0,0, 0,0,'h100,1,'hFF,0, 0,0,0,0));
    tv.push_back(v(1,'h118,4,'hFF,0,0, 0,0,0, 1,0,'h100,1,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,0,'h108,2,'hFF,0, 0,0,0,0));
    tv.push_back(v(1,'h120,5,'hFF,0,0, 0,0,0, 1,0,'h108,2,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,0,'h110,3,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,0,'h118,4,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,0,'h120,5,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    // commit on empty ignored; overlap on empty; simultaneous alloc+retire
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    tv.push_back(v(1,'h130,6,'hFF,0,1, 0,0,0, 0,0,'h130,6,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    tv.push_back(v(1,'h140,7,'hFF,0,0, 0,0,0, 0,0,'h140,7,'hFF,0, 0,0,0,0));
    tv.push_back(v(1,'h148,8,'hFF,0,1, 0,0,0, 0,0,'h148,8,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    // forwarding priority, including the same-cycle dc4 store
    tv.push_back(v(1,'h200,64'h1111_1111,'h0F,0,0, 0,0,0, 0,0,'h200,64'h1111_1111,'h0F,0, 0,0,0,0));
    tv.push_back(v(1,'h200,64'h2222,'h03,0,0, 0,0,0, 0,0,'h200,
                   C ? 64'h1111_2222 : 64'h1111_1111,'h0F,0, 0,0,0,0));
    tv.push_back(v(1,'h200,64'h33_0000_0000,'h10,0,0, 1,'h200,'h200, 0,0,'h200,
                   C ? 64'h33_1111_2222 : 64'h1111_1111, C ? 8'h1F : 8'h0F,0,
                   'h1F,64'h33_1111_2222,'h1F,64'h33_1111_2222));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,C,'h200,64'h2222,'h03,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,C,'h200,64'h33_0000_0000,'h10,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    // unaligned load hi path; retiring entry still forwards
    tv.push_back(v(1,'h308,64'h8877665544332211,'hFF,0,0, 0,0,0, 0,0,'h308,64'h8877665544332211,'hFF,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,0, 1,'h306,'h30D, 0,0,'h308,64'h8877665544332211,'hFF,0,
                   0,0,'hFF,64'h8877665544332211));
    tv.push_back(v(0,0,0,0,0,1, 1,'h308,'h30F, 0,1,0,0,0,0,
                   'hFF,64'h8877665544332211,'hFF,64'h8877665544332211));
    tv.push_back(v(0,0,0,0,0,0, 1,'h308,'h308, 0,1,0,0,0,0, 0,0,0,0));
    // coalescing
    tv.push_back(v(1,'h400,64'hAA,'h01,0,0, 0,0,0, 0,0,'h400,64'hAA,'h01,0, 0,0,0,0));
    tv.push_back(v(1,'h400,64'hBB00_0000_0000_0000,'h80,0,0, 0,0,0, 0,0,'h400,
                   C ? 64'hBB00_0000_0000_00AA : 64'hAA, C ? 8'h81 : 8'h01,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,C,'h400,64'hBB00_0000_0000_0000,'h80,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    // PIC flag: no merge across pic mismatch, forwards by address only
    tv.push_back(v(1,'h500,64'h1,'h0F,1,0, 0,0,0, 0,0,'h500,64'h1,'h0F,1, 0,0,0,0));
    tv.push_back(v(1,'h500,64'h2222_2222_0000_0000,'hF0,0,0, 1,'h504,'h504, 0,0,'h500,64'h1,'h0F,1,
                   'hFF,64'h2222_2222_0000_0001,'hFF,64'h2222_2222_0000_0001));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,0,'h500,64'h2222_2222_0000_0000,'hF0,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));
    // merge blocked when youngest is the committing head
    tv.push_back(v(1,'h600,64'h1,'h01,0,0, 0,0,0, 0,0,'h600,64'h1,'h01,0, 0,0,0,0));
    tv.push_back(v(1,'h600,64'h200,'h02,0,1, 0,0,0, 0,0,'h600,64'h200,'h02,0, 0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,         0,0,0, 0,1,0,0,0,0, 0,0,0,0));

    drv(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset reqvld", reqvld, 0);
    chk("reset haddr", haddr, 0);
    chk("reset fwd_lo_be", flo_be, 0);
    chk("reset fwd_hi", fhi, 0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      drv(tv[i].sv, tv[i].a, tv[i].d, tv[i].be, tv[i].pic, tv[i].cm, tv[i].lv, tv[i].llo, tv[i].lhi);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d full", i), full, tv[i].efull);
      chk($sformatf("row%0d empty", i), empty, tv[i].eempty);
      chk($sformatf("row%0d reqvld", i), reqvld, !tv[i].eempty);
      if (!tv[i].eempty) begin
        chk($sformatf("row%0d head_addr", i), haddr, tv[i].ha);
        chk($sformatf("row%0d head_data", i), hdata, tv[i].hd);
        chk($sformatf("row%0d head_be", i), hbe, tv[i].hbe);
        chk($sformatf("row%0d head_pic", i), hpic, tv[i].hp);
      end
      chk($sformatf("row%0d fwd_lo_be", i), flo_be, tv[i].flb);
      chk($sformatf("row%0d fwd_lo", i), flo, tv[i].fl);
      chk($sformatf("row%0d fwd_hi_be", i), fhi_be, tv[i].fhb);
      chk($sformatf("row%0d fwd_hi", i), fhi, tv[i].fh);
    end

    // reset mid-drain clears queue and dc3 outputs asynchronously
    drv(1,'h700,64'h9,'hFF,0,0,0,0,0); @(posedge clk); #1;
    drv(1,'h708,64'h9,'hFF,0,0,0,0,0); @(posedge clk); #1;
    drv(1,'h710,64'h9,'hFF,0,0,1,'h700,'h708); @(posedge clk); #1;
    drv(0,0,0,0,0,1,0,0,0);
    chk("pre-rst fwd_lo_be", flo_be, 'hFF);
    chk("pre-rst empty", empty, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst empty", empty, 1);
    chk("mid-rst reqvld", reqvld, 0);
    chk("mid-rst full", full, 0);
    chk("mid-rst fwd_lo_be", flo_be, 0);
    chk("mid-rst fwd_lo", flo, 0);
    chk("mid-rst fwd_hi_be", fhi_be, 0);
    @(negedge clk);
    rst = 1'b0;
    drv(0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    chk("post-rst empty", empty, 1);
    drv(1,'h800,64'h5A,'h0F,0,0,0,0,0);
    @(posedge clk); #1;
    drv(0,0,0,0,0,0,0,0,0);
    chk("post-rst head_addr", haddr, 'h800);
    chk("post-rst head_data", hdata, 64'h5A);
    chk("post-rst reqvld", reqvld, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

endmodule
